// File: rtl/nib_deser.sv
// Serial-to-parallel word collector for the run detector front end.
// Gathers gated serial bits into W-bit words and hands them over through a registered valid/ready output.
module nib_deser #(
  parameter int W         = 4,
  parameter int MSB_FIRST = 1,
  parameter int CW        = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  input  logic                 bit_vld,
  input  logic                 o_rdy,
  input  logic                 clr_ovf,
  output logic [W-1:0]         o_data,
  output logic                 o_vld,
  output logic                 ovf,
  output logic [$clog2(W)-1:0] bit_cnt,
  output logic [CW-1:0]        acc_cnt
);

  localparam int BW = $clog2(W);

  logic [W-1:0]  r_shReg;
  logic [BW-1:0] r_bitCnt;
  logic [W-1:0]  r_data;
  logic          r_vld;
  logic          r_ovf;
  logic [CW-1:0] r_accCnt;

  logic [W-1:0]  w_shNext;
  logic          w_done;
  logic          w_accept;
  logic          w_drop;

  always_comb begin
    w_shNext = r_shReg;
    if (MSB_FIRST != 0) w_shNext = {r_shReg[W-2:0], bit_in};
    else                w_shNext = {bit_in, r_shReg[W-1:1]};
  end

  // A held word blocks the output, so a completion under backpressure is lost.
  assign w_done   = bit_vld && (r_bitCnt == BW'(W-1));
  assign w_accept = r_vld && o_rdy;
  assign w_drop   = w_done && r_vld && !o_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shReg  <= '0;
      r_bitCnt <= '0;
    end else if (bit_vld) begin
      r_shReg  <= w_shNext;
      r_bitCnt <= w_done ? '0 : r_bitCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_vld  <= 1'b0;
    end else if (w_done && (!r_vld || w_accept)) begin
      r_data <= w_shNext;
      r_vld  <= 1'b1;
    end else if (w_accept) begin
      r_vld  <= 1'b0;
    end
  end

  // Set takes priority over clear so an overflow is never silently lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (clr_ovf) r_ovf <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_accCnt <= '0;
    else if (w_accept) r_accCnt <= r_accCnt + 1'b1;
  end

  assign o_data  = r_data;
  assign o_vld   = r_vld;
  assign ovf     = r_ovf;
  assign bit_cnt = r_bitCnt;
  assign acc_cnt = r_accCnt;

endmodule

// File: tb/tb_nib_deser.sv
// Scoreboarded bench for nib_deser: one MSB-first and one LSB-first instance,
// directed vectors with hand-computed words, monitor pops expectations on each accept.
module tb_nib_deser;

  logic       clk = 1'b0;
  logic       rst;
  logic       bitInM, bitVldM, oRdyM, clrOvfM;
  logic       bitInL, bitVldL, oRdyL, clrOvfL;
  logic [3:0] oDataM, oDataL;
  logic       oVldM, oVldL, ovfM, ovfL;
  logic [1:0] bitCntM, bitCntL;
  logic [7:0] accCntM, accCntL;

  int checks   = 0;
  int failures = 0;
  logic [3:0] qM[$];
  logic [3:0] qL[$];

  nib_deser #(.W(4), .MSB_FIRST(1), .CW(8)) dutM (
    .clk(clk), .rst(rst), .bit_in(bitInM), .bit_vld(bitVldM), .o_rdy(oRdyM),
    .clr_ovf(clrOvfM), .o_data(oDataM), .o_vld(oVldM), .ovf(ovfM),
    .bit_cnt(bitCntM), .acc_cnt(accCntM)
  );

  nib_deser #(.W(4), .MSB_FIRST(0), .CW(8)) dutL (
    .clk(clk), .rst(rst), .bit_in(bitInL), .bit_vld(bitVldL), .o_rdy(oRdyL),
    .clr_ovf(clrOvfL), .o_data(oDataL), .o_vld(oVldL), .ovf(ovfL),
    .bit_cnt(bitCntL), .acc_cnt(accCntL)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; the task returns 1 unit after the sampling edge.
  task automatic applyStimulus(input logic b, input logic v, input bit toL);
    bitInM  = toL ? 1'b0 : b;
    bitVldM = toL ? 1'b0 : v;
    bitInL  = toL ? b : 1'b0;
    bitVldL = toL ? v : 1'b0;
    @(posedge clk);
    #1;
    bitVldM = 1'b0;
    bitVldL = 1'b0;
  endtask

  task automatic sendWordM(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) applyStimulus(w[i], 1'b1, 1'b0);
  endtask

  // Each accept (valid and ready at mid-cycle) consumes the oldest expected word.
  always @(negedge clk) begin
    if (!rst && oVldM && oRdyM) begin
      if (qM.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL wordM unexpected actual=%0d expected=none", oDataM);
      end else begin
        checkOutput("wordM", 32'(oDataM), 32'(qM.pop_front()));
      end
    end
    if (!rst && oVldL && oRdyL) begin
      if (qL.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL wordL unexpected actual=%0d expected=none", oDataL);
      end else begin
        checkOutput("wordL", 32'(oDataL), 32'(qL.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bitInM = 0; bitVldM = 0; oRdyM = 0; clrOvfM = 0;
    bitInL = 0; bitVldL = 0; oRdyL = 1; clrOvfL = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_vld",    32'(oVldM),   0);
    checkOutput("rst_data",   32'(oDataM),  0);
    checkOutput("rst_bitcnt", 32'(bitCntM), 0);
    checkOutput("rst_acc",    32'(accCntM), 0);
    checkOutput("rst_ovf",    32'(ovfM),    0);
    rst = 1'b0;

    // Basic MSB-first word 1110 with ready held high.
    oRdyM = 1'b1;
    qM.push_back(4'd14);
    applyStimulus(1, 1, 0); checkOutput("t1_cnt1", 32'(bitCntM), 1);
    applyStimulus(1, 1, 0); checkOutput("t1_cnt2", 32'(bitCntM), 2);
    applyStimulus(1, 1, 0); checkOutput("t1_cnt3", 32'(bitCntM), 3);
    checkOutput("t1_novld", 32'(oVldM), 0);
    applyStimulus(0, 1, 0); checkOutput("t1_cnt0", 32'(bitCntM), 0);
    checkOutput("t1_vld",  32'(oVldM),  1);
    checkOutput("t1_data", 32'(oDataM), 14);
    applyStimulus(0, 0, 0);
    checkOutput("t1_vld_fall", 32'(oVldM),   0);
    checkOutput("t1_acc",      32'(accCntM), 1);

    // LSB-first word 1,0,<gap>,0,1 -> 1001.
    qL.push_back(4'd9);
    applyStimulus(1, 1, 1);
    applyStimulus(0, 1, 1);
    for (int g = 0; g < 3; g++) begin
      applyStimulus(0, 0, 1);
      checkOutput("t2_gap_cnt", 32'(bitCntL), 2);
      checkOutput("t2_gap_vld", 32'(oVldL),   0);
    end
    applyStimulus(0, 1, 1); checkOutput("t2_vld3", 32'(oVldL), 0);
    applyStimulus(1, 1, 1);
    checkOutput("t2_vld",  32'(oVldL),  1);
    checkOutput("t2_data", 32'(oDataL), 9);
    applyStimulus(0, 0, 1);
    checkOutput("t2_acc", 32'(accCntL), 1);

    // Backpressure: 0001 is held, 0010 is dropped.
    oRdyM = 1'b0;
    qM.push_back(4'd1);
    sendWordM(4'b0001);
    checkOutput("t3_vld",  32'(oVldM),  1);
    checkOutput("t3_data", 32'(oDataM), 1);
    checkOutput("t3_ovf0", 32'(ovfM),   0);
    sendWordM(4'b0010);
    checkOutput("t3_hold", 32'(oDataM), 1);
    checkOutput("t3_ovf1", 32'(ovfM),   1);
    checkOutput("t3_vld2", 32'(oVldM),  1);
    oRdyM = 1'b1;
    applyStimulus(0, 0, 0);
    checkOutput("t3_acc",   32'(accCntM), 2);
    checkOutput("t3_vld0",  32'(oVldM),   0);
    checkOutput("t3_ovfst", 32'(ovfM),    1);
    clrOvfM = 1'b1;
    applyStimulus(0, 0, 0);
    clrOvfM = 1'b0;
    checkOutput("t3_clr", 32'(ovfM), 0);

    // Accept of 0101 coincides with completion of 1010.
    oRdyM = 1'b0;
    qM.push_back(4'd5);
    sendWordM(4'b0101);
    checkOutput("t4_data5", 32'(oDataM), 5);
    qM.push_back(4'd10);
    applyStimulus(1, 1, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(1, 1, 0);
    checkOutput("t4_hold5", 32'(oDataM), 5);
    oRdyM = 1'b1;
    applyStimulus(0, 1, 0);
    checkOutput("t4_data10", 32'(oDataM),  10);
    checkOutput("t4_vld",    32'(oVldM),   1);
    checkOutput("t4_ovf",    32'(ovfM),    0);
    checkOutput("t4_acc",    32'(accCntM), 3);
    applyStimulus(0, 0, 0);
    checkOutput("t4_acc2", 32'(accCntM), 4);

    // Asynchronous reset between edges discards a partial word.
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    checkOutput("t5_cnt2", 32'(bitCntM), 2);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5_rst_cnt", 32'(bitCntM), 0);
    checkOutput("t5_rst_acc", 32'(accCntM), 0);
    #2 rst = 1'b0;
    qM.push_back(4'd0);
    sendWordM(4'b0000);
    checkOutput("t5_vld",  32'(oVldM),  1);
    checkOutput("t5_data", 32'(oDataM), 0);
    applyStimulus(0, 0, 0);
    checkOutput("t5_acc", 32'(accCntM), 1);

    // 256 back-to-back accepted words wrap the counter.
    rst = 1'b1;
    applyStimulus(0, 0, 0);
    rst = 1'b0;
    oRdyM = 1'b1;
    for (int k = 0; k < 256; k++) begin
      qM.push_back(4'(k));
      sendWordM(4'(k));
      if (ovfM !== 1'b0) checkOutput("t6_ovf", 32'(ovfM), 0);
    end
    checkOutput("t6_ovf_end", 32'(ovfM),    0);
    checkOutput("t6_acc255",  32'(accCntM), 255);
    applyStimulus(0, 0, 0);
    checkOutput("t6_acc0", 32'(accCntM), 0);
    checkOutput("t6_vld0", 32'(oVldM),   0);

    applyStimulus(0, 0, 0);
    checkOutput("qM_empty", 32'(qM.size()), 0);
    checkOutput("qL_empty", 32'(qL.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
